// File: rtl/serdesphy_cdr_loop_filter.sv
`default_nettype none
// ============================================================================
// Module      : serdesphy_cdr_loop_filter
// Description : Bang-bang CDR loop filter. Turns early/late phase-detector
//               votes into an 8-bit VCO control code. It is a saturating
//               12-bit integrator with a proportional kick. A windowed
//               net-vote lock detector drives the IDLE/ACQUIRE/TRACK
//               sequencing, and the integrator gain drops once locked.
// Ports       : clk          - recovered-domain clock (only clock)
//               rst          - synchronous active-high reset
//               enable       - loop enable
//               vco_ready    - VCO stable flag
//               pd_valid     - phase-detector vote qualifier
//               pd_early     - clock early, request lower frequency
//               pd_late      - clock late, request higher frequency
//               cdr_control  - registered 8-bit VCO control code
//               cdr_locked   - registered lock indicator
//               cdr_rail     - registered integrator-at-limit flag
// Revision    : 1.0 - initial release
// ============================================================================
module serdesphy_cdr_loop_filter #(
    parameter int ACQ_STEP   = 16,
    parameter int TRK_STEP   = 2,
    parameter int KP         = 2,
    parameter int WIN_LEN    = 64,
    parameter int LOCK_TOL   = 4,
    parameter int UNLOCK_TOL = 16,
    parameter int LOCK_WINS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       vco_ready,
    input  logic       pd_valid,
    input  logic       pd_early,
    input  logic       pd_late,
    output logic [7:0] cdr_control,
    output logic       cdr_locked,
    output logic       cdr_rail
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_acquire = 2'd1;
    localparam logic [1:0] c_st_track   = 2'd2;

    localparam int c_cnt_w  = $clog2(WIN_LEN + 1);
    localparam int c_good_w = $clog2(LOCK_WINS + 1);
    // Net-vote sum spans +/-WIN_LEN; 16 bits covers any sane window length.
    localparam int c_net_w  = 16;

    localparam logic [11:0]          c_integ_mid = 12'h800;
    localparam logic [11:0]          c_integ_max = 12'hFFF;
    localparam logic [7:0]           c_ctrl_mid  = 8'h80;
    localparam logic [c_cnt_w-1:0]   c_win_last  = c_cnt_w'(WIN_LEN - 1);
    localparam logic [c_good_w-1:0]  c_good_last = c_good_w'(LOCK_WINS - 1);
    localparam logic signed [13:0]   c_acq_step  = 14'(ACQ_STEP);
    localparam logic signed [13:0]   c_trk_step  = 14'(TRK_STEP);
    localparam logic signed [9:0]    c_kp        = 10'(KP);
    localparam logic [c_net_w-1:0]   c_lock_tol  = c_net_w'(LOCK_TOL);
    localparam logic [c_net_w-1:0]   c_unlk_tol  = c_net_w'(UNLOCK_TOL);

    logic [1:0]                 r_state;
    logic [11:0]                r_integ;
    logic [c_cnt_w-1:0]         r_win_cnt;
    logic signed [c_net_w-1:0]  r_win_net;
    logic [c_good_w-1:0]        r_good_cnt;

    logic                       w_active;
    logic                       w_valid;
    logic                       w_up;
    logic                       w_dn;
    logic signed [13:0]         w_step;
    logic signed [13:0]         w_integ_sum;
    logic [11:0]                w_integ_next;
    logic signed [9:0]          w_ctrl_sum;
    logic [7:0]                 w_ctrl_next;
    logic                       w_rail_next;
    logic signed [c_net_w-1:0]  w_net_new;
    logic [c_net_w-1:0]         w_net_abs;
    logic                       w_win_done;
    logic                       w_win_good;
    logic                       w_win_bad;

    // Votes only count while the loop is running; IDLE ignores the detector.
    assign w_active = (r_state == c_st_acquire) || (r_state == c_st_track);
    assign w_valid  = w_active & pd_valid;
    assign w_up     = w_valid & pd_late & ~pd_early;
    assign w_dn     = w_valid & pd_early & ~pd_late;

    assign w_step = (r_state == c_st_track) ? c_trk_step : c_acq_step;

    always_comb begin
        w_integ_sum = $signed({2'b00, r_integ});
        if (w_up) begin
            w_integ_sum = $signed({2'b00, r_integ}) + w_step;
        end else if (w_dn) begin
            w_integ_sum = $signed({2'b00, r_integ}) - w_step;
        end
    end

    // Clamp to the 12-bit range rather than wrap.
    always_comb begin
        w_integ_next = w_integ_sum[11:0];
        if (!w_active) begin
            w_integ_next = c_integ_mid;
        end else if (w_integ_sum < 14'sd0) begin
            w_integ_next = 12'h000;
        end else if (w_integ_sum > 14'sd4095) begin
            w_integ_next = c_integ_max;
        end
    end

    // Proportional path rides on the top 8 integrator bits.
    always_comb begin
        w_ctrl_sum = $signed({2'b00, w_integ_next[11:4]});
        if (w_up) begin
            w_ctrl_sum = $signed({2'b00, w_integ_next[11:4]}) + c_kp;
        end else if (w_dn) begin
            w_ctrl_sum = $signed({2'b00, w_integ_next[11:4]}) - c_kp;
        end
        if (w_ctrl_sum < 10'sd0) begin
            w_ctrl_next = 8'h00;
        end else if (w_ctrl_sum > 10'sd255) begin
            w_ctrl_next = 8'hFF;
        end else begin
            w_ctrl_next = w_ctrl_sum[7:0];
        end
    end

    assign w_rail_next = w_active &&
                         ((w_integ_next == 12'h000) || (w_integ_next == c_integ_max));

    // The window judgement includes the vote that closes it.
    always_comb begin
        w_net_new = r_win_net;
        if (w_up) begin
            w_net_new = r_win_net + c_net_w'(1);
        end else if (w_dn) begin
            w_net_new = r_win_net - c_net_w'(1);
        end
    end

    assign w_net_abs  = w_net_new[c_net_w-1] ? c_net_w'(-w_net_new) : c_net_w'(w_net_new);
    assign w_win_done = w_valid && (r_win_cnt == c_win_last);
    assign w_win_good = w_net_abs <= c_lock_tol;
    assign w_win_bad  = w_net_abs >  c_unlk_tol;

    always_ff @(posedge clk) begin
        if (rst || !(enable && vco_ready)) begin
            r_state     <= c_st_idle;
            r_integ     <= c_integ_mid;
            r_win_cnt   <= '0;
            r_win_net   <= '0;
            r_good_cnt  <= '0;
            cdr_control <= c_ctrl_mid;
            cdr_locked  <= 1'b0;
            cdr_rail    <= 1'b0;
        end else begin
            r_integ     <= w_integ_next;
            cdr_control <= w_ctrl_next;
            cdr_rail    <= w_rail_next;

            if (w_valid) begin
                if (w_win_done) begin
                    r_win_cnt <= '0;
                    r_win_net <= '0;
                end else begin
                    r_win_cnt <= r_win_cnt + c_cnt_w'(1);
                    r_win_net <= w_net_new;
                end
            end

            case (r_state)
                c_st_idle: begin
                    r_state <= c_st_acquire;
                end
                c_st_acquire: begin
                    if (w_win_done) begin
                        if (!w_win_good) begin
                            r_good_cnt <= '0;
                        end else if (r_good_cnt == c_good_last) begin
                            r_state    <= c_st_track;
                            r_good_cnt <= '0;
                            cdr_locked <= 1'b1;
                        end else begin
                            r_good_cnt <= r_good_cnt + c_good_w'(1);
                        end
                    end
                end
                c_st_track: begin
                    // Integrator is left untouched; only the gain changes back.
                    if (w_win_done && w_win_bad) begin
                        r_state    <= c_st_acquire;
                        r_good_cnt <= '0;
                        cdr_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= c_st_idle;
                    cdr_locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serdesphy_cdr_loop_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_serdesphy_cdr_loop_filter
// Description : Self-checking bench for serdesphy_cdr_loop_filter. Every
//               driven cycle runs an integer reference model and queues the
//               expected {control, locked, rail}; the queue is popped and
//               compared one clock later. Directed checks against fixed
//               constants cover acquisition, lock, unlock, saturation,
//               VCO drop and double votes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serdesphy_cdr_loop_filter;

    localparam int ACQ_STEP   = 16;
    localparam int TRK_STEP   = 2;
    localparam int KP         = 2;
    localparam int WIN_LEN    = 64;
    localparam int LOCK_TOL   = 4;
    localparam int UNLOCK_TOL = 16;
    localparam int LOCK_WINS  = 4;

    localparam int K_LATE  = 0;
    localparam int K_EARLY = 1;
    localparam int K_ALT   = 2;
    localparam int K_BOTH  = 3;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       vco_ready;
    logic       pd_valid;
    logic       pd_early;
    logic       pd_late;
    logic [7:0] cdr_control;
    logic       cdr_locked;
    logic       cdr_rail;

    serdesphy_cdr_loop_filter #(
        .ACQ_STEP  (ACQ_STEP),
        .TRK_STEP  (TRK_STEP),
        .KP        (KP),
        .WIN_LEN   (WIN_LEN),
        .LOCK_TOL  (LOCK_TOL),
        .UNLOCK_TOL(UNLOCK_TOL),
        .LOCK_WINS (LOCK_WINS)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .vco_ready  (vco_ready),
        .pd_valid   (pd_valid),
        .pd_early   (pd_early),
        .pd_late    (pd_late),
        .cdr_control(cdr_control),
        .cdr_locked (cdr_locked),
        .cdr_rail   (cdr_rail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] exp_q[$];

    // Reference model state (0 idle, 1 acquire, 2 track)
    int m_state, m_integ, m_cnt, m_net, m_good;
    int m_ctrl, m_lock, m_rail;
    int alt_ph;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp(input int x, input int lo, input int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    task automatic model_step(input bit r, input bit en, input bit rdy,
                              input bit pv, input bit pe, input bit pl);
        int v, a;
        if (r || !(en && rdy)) begin
            m_state = 0; m_integ = 2048; m_cnt = 0; m_net = 0; m_good = 0;
            m_ctrl = 128; m_lock = 0; m_rail = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_ctrl = 128; m_rail = 0;
        end else begin
            v = 0;
            if (pv && pl && !pe) v = 1;
            if (pv && pe && !pl) v = -1;
            m_integ = clamp(m_integ + v * ((m_state == 1) ? ACQ_STEP : TRK_STEP), 0, 4095);
            m_ctrl  = clamp(m_integ / 16 + v * KP, 0, 255);
            m_rail  = (m_integ == 0 || m_integ == 4095) ? 1 : 0;
            if (pv) begin
                m_cnt++;
                m_net += v;
                if (m_cnt == WIN_LEN) begin
                    a = (m_net < 0) ? -m_net : m_net;
                    if (m_state == 1) begin
                        if (a <= LOCK_TOL) begin
                            m_good++;
                            if (m_good == LOCK_WINS) begin
                                m_state = 2; m_lock = 1; m_good = 0;
                            end
                        end else begin
                            m_good = 0;
                        end
                    end else if (a > UNLOCK_TOL) begin
                        m_state = 1; m_lock = 0; m_good = 0;
                    end
                    m_cnt = 0;
                    m_net = 0;
                end
            end
        end
        exp_q.push_back({m_ctrl[7:0], m_lock[0], m_rail[0]});
    endtask

    // One clock: drive, predict, clock, compare against the queued prediction.
    task automatic step(input bit r, input bit en, input bit rdy,
                        input bit pv, input bit pe, input bit pl);
        logic [9:0] e;
        rst = r; enable = en; vco_ready = rdy;
        pd_valid = pv; pd_early = pe; pd_late = pl;
        model_step(r, en, rdy, pv, pe, pl);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("sb_out", {22'd0, cdr_control, cdr_locked, cdr_rail}, {22'd0, e});
        end
    endtask

    task automatic run_votes(input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            case (kind)
                K_LATE:  step(0, 1, 1, 1, 0, 1);
                K_EARLY: step(0, 1, 1, 1, 1, 0);
                K_BOTH:  step(0, 1, 1, 1, 1, 1);
                default: begin
                    if (alt_ph == 0) step(0, 1, 1, 1, 0, 1);
                    else             step(0, 1, 1, 1, 1, 0);
                    alt_ph = 1 - alt_ph;
                end
            endcase
        end
    endtask

    task automatic do_reset();
        step(1, 1, 1, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);   // IDLE -> ACQUIRE
        alt_ph = 0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; vco_ready = 1'b0;
        pd_valid = 1'b0; pd_early = 1'b0; pd_late = 1'b0;
        alt_ph = 0;

        // Reset state
        step(1, 1, 1, 1, 0, 1);
        check_eq("rst_ctrl", {24'd0, cdr_control}, 32'h80);
        check_eq("rst_lock", {31'd0, cdr_locked}, 32'd0);
        check_eq("rst_rail", {31'd0, cdr_rail}, 32'd0);
        step(0, 1, 1, 0, 0, 0);

        // Ten late votes from mid-scale
        run_votes(10, K_LATE);
        check_eq("late10_ctrl", {24'd0, cdr_control}, 32'h8C);
        check_eq("late10_lock", {31'd0, cdr_locked}, 32'd0);
        step(0, 1, 1, 0, 0, 0);
        check_eq("late10_hold", {24'd0, cdr_control}, 32'h8A);

        // Four balanced windows -> lock on the 256th vote
        do_reset();
        run_votes(255, K_ALT);
        check_eq("lock_255", {31'd0, cdr_locked}, 32'd0);
        run_votes(1, K_ALT);
        check_eq("lock_256", {31'd0, cdr_locked}, 32'd1);

        // One all-late window in TRACK -> unlock, integrator kept at 0x880
        run_votes(63, K_LATE);
        check_eq("unlock_63", {31'd0, cdr_locked}, 32'd1);
        run_votes(1, K_LATE);
        check_eq("unlock_64", {31'd0, cdr_locked}, 32'd0);
        check_eq("unlock_ctrl", {24'd0, cdr_control}, 32'h8A);
        step(0, 1, 1, 0, 0, 0);
        check_eq("unlock_keep", {24'd0, cdr_control}, 32'h88);

        // Saturation at both rails
        run_votes(300, K_LATE);
        check_eq("sat_hi_ctrl", {24'd0, cdr_control}, 32'hFF);
        check_eq("sat_hi_rail", {31'd0, cdr_rail}, 32'd1);
        step(0, 1, 1, 0, 0, 0);
        check_eq("sat_hi_hold", {24'd0, cdr_control}, 32'hFF);
        run_votes(300, K_EARLY);
        check_eq("sat_lo_ctrl", {24'd0, cdr_control}, 32'h00);
        check_eq("sat_lo_rail", {31'd0, cdr_rail}, 32'd1);

        // Double votes: no movement, but a good window
        do_reset();
        run_votes(64, K_BOTH);
        check_eq("both_ctrl", {24'd0, cdr_control}, 32'h80);
        check_eq("both_rail", {31'd0, cdr_rail}, 32'd0);
        run_votes(191, K_ALT);
        check_eq("both_lock_255", {31'd0, cdr_locked}, 32'd0);
        run_votes(1, K_ALT);
        check_eq("both_lock_256", {31'd0, cdr_locked}, 32'd1);

        // VCO drop mid-window while locked, then a full re-acquisition
        run_votes(30, K_ALT);
        step(0, 1, 0, 1, 0, 1);
        check_eq("drop_ctrl", {24'd0, cdr_control}, 32'h80);
        check_eq("drop_lock", {31'd0, cdr_locked}, 32'd0);
        step(0, 1, 1, 0, 0, 0);
        alt_ph = 0;
        run_votes(255, K_ALT);
        check_eq("relock_255", {31'd0, cdr_locked}, 32'd0);
        run_votes(1, K_ALT);
        check_eq("relock_256", {31'd0, cdr_locked}, 32'd1);

        // Reset mid-window discards the partial window
        run_votes(20, K_LATE);
        do_reset();
        run_votes(255, K_ALT);
        check_eq("rstmid_255", {31'd0, cdr_locked}, 32'd0);
        run_votes(1, K_ALT);
        check_eq("rstmid_256", {31'd0, cdr_locked}, 32'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit r, en, pv, pe, pl;
            r  = ($urandom_range(0, 499) == 0);
            en = ($urandom_range(0, 399) != 0);
            pv = ($urandom_range(0, 9) < 7);
            pe = $urandom_range(0, 1);
            pl = (i % 1000 < 500) ? !pe : ($urandom_range(0, 3) != 0);
            step(r, en, 1'b1, pv, pe, pl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
